// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared opcodes, FSM state type and width defaults for instr_fetch
package fetch_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 4;

  // Opcodes live in instr[7:4]; LDI/MOV are decoded by the ROM, not here.
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_JNZ = 4'h3;
  localparam logic [3:0] OP_J   = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - 2**AW x DW program store, synchronous write, asynchronous read
module prog_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // No reset: program contents survive rst so a reloaded run is optional.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program store, PC and fetch/exec sequencer feeding the decode ROM
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int            DW         = DW_DEFAULT,
  parameter int            AW         = AW_DEFAULT,
  parameter logic [AW-1:0] START_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          zero,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  fetch_state_t  state, state_n;
  logic [AW-1:0] pc_n;
  logic [DW-1:0] instr_n;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [3:0]    op;
  logic [AW-1:0] imm;

  assign op  = instr[DW-1:DW-4];
  assign imm = instr[AW-1:0];

  prog_mem #(
    .DW (DW),
    .AW (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= START_ADDR;
      instr <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      instr <= instr_n;
    end
  end

  // Stall freezes everything, including program writes and the zero sample.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    instr_n     = instr;
    mem_we      = 1'b0;
    instr_valid = 1'b0;
    if (!stall) begin
      unique case (state)
        ST_IDLE, ST_HALT: begin
          mem_we = prog_we;
          if (start) begin
            state_n = ST_FETCH;
            pc_n    = START_ADDR;
          end
        end
        ST_FETCH: begin
          instr_n = rdata;
          pc_n    = pc + AW'(1);
          state_n = ST_EXEC;
        end
        ST_EXEC: begin
          instr_valid = 1'b1;
          state_n     = ST_FETCH;
          if (op == OP_J) begin
            pc_n = imm;
            // pc already points past this instruction, so pc-1 is its own address.
            if (imm == pc - AW'(1)) begin
              state_n = ST_HALT;
            end
          end else if (op == OP_JNZ && !zero) begin
            pc_n = imm;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy   = (state == ST_FETCH) || (state == ST_EXEC);
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       zero = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy;
  logic       halted;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .zero        (zero),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_v = -1;
  int         start_cyc = 0;
  bit         gap_en = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] model_mem[16];
  logic [3:0] exp_pc;
  bit         exp_halt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check_eq("instr", {24'd0, instr}, {24'd0, exp_q.pop_front()});
        if (gap_en) begin
          if (last_v < 0) check_eq("latency", cyc - start_cyc, 2);
          else            check_eq("gap", cyc - last_v, 2);
        end
        last_v = cyc;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    model_mem[a] = d;
  endtask

  // Walks the program from address 0 and queues every executed instruction.
  task automatic model_run(input logic z, input int maxn);
    logic [3:0] p;
    logic [3:0] addr;
    logic [7:0] ins;
    p = 4'h0;
    exp_halt = 1'b0;
    for (int n = 0; n < maxn; n++) begin
      addr = p;
      ins  = model_mem[addr];
      exp_q.push_back(ins);
      p = addr + 4'd1;
      if (ins[7:4] == 4'h7) begin
        p = ins[3:0];
        if (ins[3:0] == addr) begin
          exp_halt = 1'b1;
          break;
        end
      end else if (ins[7:4] == 4'h3 && !z) begin
        p = ins[3:0];
      end
    end
    exp_pc = p;
  endtask

  task automatic go;
    last_v    = -1;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_q(input int left, input int budget);
    int n = 0;
    while (exp_q.size() > left && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("timeout", {31'd0, exp_q.size() > left}, 32'd0);
  endtask

  task automatic finish_run(input string tag);
    wait_q(0, 200);
    #1;
    check_eq({tag, "_pc"}, {28'd0, pc}, {28'd0, exp_pc});
    check_eq({tag, "_halted"}, {31'd0, halted}, {31'd0, exp_halt});
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit found;
    #12;
    check_eq("rst_instr", {24'd0, instr}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_pc", {28'd0, pc}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Straight-line program ending in a self-jump; writes and start ignored while busy.
    load(4'h0, 8'h23); load(4'h1, 8'h48); load(4'h2, 8'h0C); load(4'h3, 8'h73);
    model_run(1'b0, 16);
    go();
    check_eq("busy_fetch", {31'd0, busy}, 32'd1);
    prog_we = 1'b1; prog_addr = 4'h2; prog_data = 8'hBA; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    finish_run("seq");

    // Write after halt takes effect on restart.
    load(4'h2, 8'hBA);
    model_run(1'b0, 16);
    go();
    finish_run("rewrite");

    // JNZ taken and not taken.
    load(4'h0, 8'h38); load(4'h1, 8'h71); load(4'h8, 8'h78);
    zero = 1'b0;
    model_run(1'b0, 16);
    go();
    finish_run("jnz_taken");
    zero = 1'b1;
    model_run(1'b1, 16);
    go();
    finish_run("jnz_fall");

    // Three stalled EXEC cycles.
    load(4'h0, 8'h66); load(4'h1, 8'h71);
    model_run(1'b0, 16);
    gap_en = 1'b0;
    go();
    tick();
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("stall_pc", {28'd0, pc}, 32'd1);
      check_eq("stall_instr", {24'd0, instr}, 32'h66);
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    finish_run("stall");
    gap_en = 1'b1;

    // PC wrap from 4'hF, then async reset mid-EXEC.
    zero = 1'b0;
    load(4'h0, 8'h3F); load(4'hF, 8'h20); load(4'h1, 8'h71);
    model_run(1'b0, 6);
    go();
    wait_q(2, 200);
    #1;
    check_eq("wrap_pc", {28'd0, pc}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #2;
      if (instr_valid) found = 1'b1;
    end
    check_eq("found_exec", {31'd0, found}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("arst_instr", {24'd0, instr}, 32'd0);
    check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("arst_pc", {28'd0, pc}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_halted", {31'd0, halted}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    zero = 1'b1;
    model_run(1'b1, 16);
    go();
    finish_run("retain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
